// File: rtl/gen_adc_ser_model.sv
// Serial ADC output model: frames parallel samples onto CHANNELS LVDS-style lanes with a frame clock.
// Optional ramp test pattern (TEST_MODE port) is built when GEN_ADC_SER_TEST_PATTERN_EN is defined.
module gen_adc_ser_model #(
    parameter int CHANNELS  = 4,
    parameter int BITS      = 14,
    parameter int FRAME_LEN = 16,
    parameter int SYNC_DLY  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENABLE,
`ifdef GEN_ADC_SER_TEST_PATTERN_EN
    input  logic                     TEST_MODE,
`endif
    input  logic [CHANNELS*BITS-1:0] DATA_IN,
    input  logic                     DATA_VALID,
    output logic                     DATA_READY,
    output logic                     ADC_FCO,
    output logic [CHANNELS-1:0]      ADC_DATA,
    output logic                     FRAME_START,
    output logic [7:0]               UNDERRUN_CNT
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int SW = (SYNC_DLY > 1) ? $clog2(SYNC_DLY) : 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SYNC = 2'd1, ST_RUN = 2'd2} state_t;

    state_t                         state_reg, state_next;
    logic [CW-1:0]                  bit_cnt_reg;
    logic [SW-1:0]                  sync_cnt_reg;
    logic                           stop_pend_reg;
    logic [CHANNELS-1:0][BITS-1:0]  shift_reg, hold_reg, prev_reg, load_word;
    logic                           hold_full_reg;
    logic [7:0]                     underrun_reg;
    logic                           wrap, load, take_hold, underrun_evt, hold_wr, run;

    assign wrap = (bit_cnt_reg == CW'(FRAME_LEN - 1));
    assign run  = (state_reg == ST_RUN);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: if (ENABLE) state_next = ST_SYNC;
            ST_SYNC: begin
                if (!ENABLE) begin
                    state_next = ST_IDLE;
                end else if (sync_cnt_reg == SW'(SYNC_DLY - 1)) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                // A stop request only takes effect once the current frame has been fully sent
                if (wrap) begin
                    if (stop_pend_reg || !ENABLE) state_next = ST_IDLE;
                    else                          load       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef GEN_ADC_SER_TEST_PATTERN_EN
    logic [BITS-1:0]               ramp_reg;
    logic [CHANNELS-1:0][BITS-1:0] test_word;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ramp
        assign test_word[gi] = ramp_reg + BITS'(gi);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       ramp_reg <= '0;
        else if (load) ramp_reg <= ramp_reg + BITS'(1);
    end
`endif

    // Source priority at a load edge: holding register, then live bypass, then repeat last sample
    always_comb begin
        load_word    = prev_reg;
        take_hold    = 1'b0;
        underrun_evt = 1'b0;
        if (hold_full_reg) begin
            load_word = hold_reg;
            take_hold = 1'b1;
        end else if (DATA_VALID) begin
            load_word = DATA_IN;
        end else begin
            underrun_evt = 1'b1;
        end
`ifdef GEN_ADC_SER_TEST_PATTERN_EN
        if (TEST_MODE) begin
            load_word    = test_word;
            take_hold    = 1'b0;
            underrun_evt = 1'b0;
        end
`endif
    end

    assign hold_wr = DATA_VALID && !hold_full_reg && !load;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            sync_cnt_reg  <= '0;
            stop_pend_reg <= 1'b0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            prev_reg      <= '0;
            hold_full_reg <= 1'b0;
            underrun_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            sync_cnt_reg <= (state_reg == ST_SYNC && state_next == ST_SYNC) ?
                            sync_cnt_reg + SW'(1) : '0;
            if (run && state_next == ST_RUN) begin
                bit_cnt_reg   <= wrap ? '0 : bit_cnt_reg + CW'(1);
                stop_pend_reg <= stop_pend_reg | ~ENABLE;
            end else begin
                bit_cnt_reg   <= '0;
                stop_pend_reg <= 1'b0;
            end

            if (load) begin
                shift_reg <= load_word;
                prev_reg  <= load_word;
                if (underrun_evt && underrun_reg != 8'hFF)
                    underrun_reg <= underrun_reg + 8'd1;
            end else if (run) begin
                for (int i = 0; i < CHANNELS; i++)
                    shift_reg[i] <= shift_reg[i] << 1;
            end

            if (load && take_hold) begin
                hold_full_reg <= 1'b0;
            end else if (hold_wr) begin
                hold_reg      <= DATA_IN;
                hold_full_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        assign ADC_DATA[gi] = run & shift_reg[gi][BITS-1];
    end

    assign ADC_FCO      = run && (bit_cnt_reg < CW'(FRAME_LEN / 2));
    assign FRAME_START  = run && (bit_cnt_reg == '0);
    assign DATA_READY   = ~hold_full_reg;
    assign UNDERRUN_CNT = underrun_reg;
endmodule

// File: tb/tb_gen_adc_ser_model.sv
// Directed bench for gen_adc_ser_model: default 4x14/16 instance and a 1x12/12 instance.
// Ramp pattern frames are exercised when GEN_ADC_SER_TEST_PATTERN_EN is defined.
module tb_gen_adc_ser_model;
    logic        CLK;
    logic        rst_a, rst_b;
    logic        a_enable, a_valid, a_ready, a_fco, a_fs;
    logic [55:0] a_data_in;
    logic [3:0]  a_adc_data;
    logic [7:0]  a_underrun;
    logic        b_enable, b_valid, b_ready, b_fco, b_fs;
    logic [11:0] b_data_in;
    logic [0:0]  b_adc_data;
    logic [7:0]  b_underrun;
`ifdef GEN_ADC_SER_TEST_PATTERN_EN
    logic        test_mode;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_wait;

    logic [15:0] cap_lane [4];
    logic [15:0] cap_fco, cap_fs;
    logic [11:0] b_lane, b_fco_pat, b_fs_pat;

    gen_adc_ser_model u_dut_a (
        .CLK          (CLK),
        .RST          (rst_a),
        .ENABLE       (a_enable),
`ifdef GEN_ADC_SER_TEST_PATTERN_EN
        .TEST_MODE    (test_mode),
`endif
        .DATA_IN      (a_data_in),
        .DATA_VALID   (a_valid),
        .DATA_READY   (a_ready),
        .ADC_FCO      (a_fco),
        .ADC_DATA     (a_adc_data),
        .FRAME_START  (a_fs),
        .UNDERRUN_CNT (a_underrun)
    );

    gen_adc_ser_model #(.CHANNELS(1), .BITS(12), .FRAME_LEN(12), .SYNC_DLY(2)) u_dut_b (
        .CLK          (CLK),
        .RST          (rst_b),
        .ENABLE       (b_enable),
`ifdef GEN_ADC_SER_TEST_PATTERN_EN
        .TEST_MODE    (1'b0),
`endif
        .DATA_IN      (b_data_in),
        .DATA_VALID   (b_valid),
        .DATA_READY   (b_ready),
        .ADC_FCO      (b_fco),
        .ADC_DATA     (b_adc_data),
        .FRAME_START  (b_fs),
        .UNDERRUN_CNT (b_underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Records one 16-cycle frame of instance A, starting in its counter-0 cycle
    task automatic capture_a;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) cap_lane[i] = {cap_lane[i][14:0], a_adc_data[i]};
            cap_fco = {cap_fco[14:0], a_fco};
            cap_fs  = {cap_fs[14:0], a_fs};
            tick();
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_enable = 1'b0; a_valid = 1'b0; a_data_in = '0;
        b_enable = 1'b0; b_valid = 1'b0; b_data_in = '0;
`ifdef GEN_ADC_SER_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        #1;
        check_eq("rst_ready", a_ready, 1);
        check_eq("rst_fco", a_fco, 0);
        check_eq("rst_fs", a_fs, 0);
        check_eq("rst_data", a_adc_data, 0);
        check_eq("rst_underrun", a_underrun, 0);
        tick_n(2);
        rst_a = 1'b0;
        tick();

        // Preload holding in IDLE, then start framing
        a_data_in = {14'h0001, 14'h3FFF, 14'h1555, 14'h2AAA};
        a_valid   = 1'b1;
        tick();
        a_valid   = 1'b0;
        check_eq("preload_ready", a_ready, 0);
        check_eq("idle_fco", a_fco, 0);
        a_enable = 1'b1;
        n_wait = 0;
        while (!a_fs && n_wait < 10) begin
            tick();
            n_wait++;
        end
        check_eq("sync_latency", n_wait, 3);

        capture_a();
        check_eq("f1_lane0", cap_lane[0], 16'hAAA8);
        check_eq("f1_lane1", cap_lane[1], 16'h5554);
        check_eq("f1_lane2", cap_lane[2], 16'hFFFC);
        check_eq("f1_lane3", cap_lane[3], 16'h0004);
        check_eq("f1_fco", cap_fco, 16'hFF00);
        check_eq("f1_fs", cap_fs, 16'h8000);
        check_eq("f2_ready", a_ready, 1);
        check_eq("f2_underrun", a_underrun, 1);

        // Underrun: the same word repeats
        capture_a();
        capture_a();
        check_eq("f4_underrun", a_underrun, 3);
        capture_a();
        check_eq("f4_lane0", cap_lane[0], 16'hAAA8);
        check_eq("f4_lane3", cap_lane[3], 16'h0004);
        check_eq("f4_fs", cap_fs, 16'h8000);

        // Bypass: valid only on the load edge
        tick_n(15);
        a_data_in = {14'h0F0F, 14'h00FF, 14'h3000, 14'h1234};
        a_valid   = 1'b1;
        tick();
        a_valid   = 1'b0;
        check_eq("byp_ready", a_ready, 1);
        check_eq("byp_underrun", a_underrun, 4);
        capture_a();
        check_eq("byp_lane0", cap_lane[0], 16'h48D0);
        check_eq("byp_lane1", cap_lane[1], 16'hC000);
        check_eq("byp_lane3", cap_lane[3], 16'h3C3C);
        check_eq("f7_underrun", a_underrun, 5);

        // Stop at counter 5: frame still completes
        tick_n(5);
        a_enable = 1'b0;
        tick_n(2);
        check_eq("stop_c7_fco", a_fco, 1);
        tick();
        check_eq("stop_c8_lane0", a_adc_data[0], 1);
        check_eq("stop_c8_fco", a_fco, 0);
        tick_n(8);
        check_eq("stop_idle_fs", a_fs, 0);
        check_eq("stop_idle_data", a_adc_data, 0);
        tick_n(20);
        check_eq("stop_stays_idle", {a_fs, a_fco}, 0);

        // Restart, fill holding, then reset at counter 7
        a_enable = 1'b1;
        tick_n(3);
        check_eq("restart_fs", a_fs, 1);
        tick_n(3);
        a_data_in = {14'h0111, 14'h0222, 14'h0333, 14'h0444};
        a_valid   = 1'b1;
        tick();
        a_valid   = 1'b0;
        check_eq("run_hold_ready", a_ready, 0);
        tick_n(3);
        check_eq("pre_rst_fco", a_fco, 1);
        rst_a = 1'b1;
        a_enable = 1'b0;
        #1;
        check_eq("mid_rst_fco", a_fco, 0);
        check_eq("mid_rst_fs", a_fs, 0);
        check_eq("mid_rst_data", a_adc_data, 0);
        check_eq("mid_rst_ready", a_ready, 1);
        check_eq("mid_rst_underrun", a_underrun, 0);
        tick();
        rst_a = 1'b0;
        tick_n(3);
        check_eq("post_rst_quiet", {a_fs, a_fco, a_adc_data}, 0);

        // Narrow instance: 12-bit frame, no padding
        rst_b = 1'b0;
        tick();
        b_data_in = 12'hABC;
        b_valid   = 1'b1;
        tick();
        b_valid   = 1'b0;
        check_eq("b_preload_ready", b_ready, 0);
        b_enable = 1'b1;
        tick_n(3);
        for (int c = 0; c < 12; c++) begin
            b_lane    = {b_lane[10:0], b_adc_data[0]};
            b_fco_pat = {b_fco_pat[10:0], b_fco};
            b_fs_pat  = {b_fs_pat[10:0], b_fs};
            tick();
        end
        check_eq("b_lane", b_lane, 12'hABC);
        check_eq("b_fco", b_fco_pat, 12'hFC0);
        check_eq("b_fs", b_fs_pat, 12'h800);
        check_eq("b_next_fs", b_fs, 1);
        check_eq("b_ready", b_ready, 1);
        check_eq("b_underrun", b_underrun, 1);

`ifdef GEN_ADC_SER_TEST_PATTERN_EN
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        test_mode = 1'b1;
        a_enable  = 1'b1;
        tick_n(3);
        capture_a();
        check_eq("tp_f0_lane2", cap_lane[2], 16'h0008);
        capture_a();
        check_eq("tp_f1_lane2", cap_lane[2], 16'h000C);
        capture_a();
        check_eq("tp_f2_lane2", cap_lane[2], 16'h0010);
        check_eq("tp_f2_lane3", cap_lane[3], 16'h0014);
        check_eq("tp_underrun", a_underrun, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
